// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one R2SDF stage: delay-line shift, butterfly select, twiddle address, output strobes, flush.
// Optional FRAME_CNT_EN adds a 16-bit completed-frame counter output frame_cnt.
module sdf_stage_ctrl #(
  parameter int unsigned DELAY   = 16,
  parameter int unsigned TW_STEP = 1,
  parameter int unsigned TW_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_start,
  output logic            in_ready,
  output logic            sr_en,
  output logic            bf_sel,
  output logic            zero_in,
  output logic [TW_W-1:0] tw_addr,
  output logic            tw_en,
  output logic            out_valid,
  output logic            out_start,
  output logic            busy,
  output logic            sync_err
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0]     frame_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(2 * DELAY);
  localparam int unsigned LOG_D = $clog2(DELAY);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DELAY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * DELAY - 1);
  localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(DELAY - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d;
  logic             sync_err_q, sync_err_d;

  logic             acc, is_start, cnt_zero, resync, shift, last_acc;
  logic [CNT_W-1:0] eff_cnt;
  logic             primed_eff;

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
`endif

  // Accept/decode terms shared by the next-state and output logic.
  always_comb begin
    acc      = in_valid & (state_q != S_FLUSH);
    is_start = acc & in_start;
    cnt_zero = (cnt_q == '0);
    resync   = (state_q == S_RUN) & is_start & ~cnt_zero;
    shift    = is_start | ((state_q == S_RUN) & ~cnt_zero & acc);
    last_acc = (state_q == S_RUN) & acc & ~in_start & (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      sync_err_q <= sync_err_d;
    end
  end

`ifdef FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else if (last_acc) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  // In RUN, cnt==0 only occurs right after a frame wrap; it is the decision point for continue vs flush.
  // In FLUSH, cnt doubles as the flush-cycle index.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    primed_d   = primed_q;
    sync_err_d = sync_err_q | resync;
    case (state_q)
      S_IDLE: begin
        if (is_start) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(1);
        end
      end
      S_RUN: begin
        if (cnt_zero) begin
          if (is_start) begin
            cnt_d = CNT_W'(1);
          end else begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end
        end else if (resync) begin
          cnt_d    = CNT_W'(1);
          primed_d = 1'b0;
        end else if (acc) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_acc) begin
            primed_d = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == FL_LAST) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          primed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A sample carrying in_start is always treated as sample 0, whatever the registered count says.
  always_comb begin
    eff_cnt    = (is_start || state_q == S_IDLE) ? '0 : cnt_q;
    primed_eff = primed_q & ~resync;
  end

  always_comb begin
    in_ready  = (state_q != S_FLUSH);
    sr_en     = 1'b0;
    bf_sel    = 1'b0;
    zero_in   = 1'b0;
    tw_addr   = '0;
    tw_en     = 1'b0;
    out_valid = 1'b0;
    out_start = 1'b0;
    busy      = (state_q != S_IDLE);
    sync_err  = sync_err_q;
    if (state_q == S_FLUSH) begin
      sr_en     = 1'b1;
      zero_in   = 1'b1;
      out_valid = 1'b1;
      tw_en     = 1'b1;
      tw_addr   = TW_W'(32'(cnt_q[LOG_D-1:0]) * TW_STEP);
    end else begin
      sr_en     = shift;
      bf_sel    = (eff_cnt >= CNT_HALF);
      out_valid = shift & (bf_sel | primed_eff);
      out_start = shift & (eff_cnt == CNT_HALF);
      tw_en     = out_valid & ~bf_sel;
      if (!bf_sel) begin
        tw_addr = TW_W'(32'(eff_cnt[LOG_D-1:0]) * TW_STEP);
      end
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed self-checking bench for sdf_stage_ctrl (DELAY=16/TW_STEP=1 and DELAY=8/TW_STEP=2 instances).
module tb_sdf_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, in_start = 1'b0;
  logic       in_ready, sr_en, bf_sel, zero_in, tw_en, out_valid, out_start, busy, sync_err;
  logic [3:0] tw_addr;

  logic       v8 = 1'b0, s8 = 1'b0;
  logic       ir8, sr8, bf8, zi8, te8, ov8, os8, bz8, se8;
  logic [3:0] ta8;

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt, frame_cnt8;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sdf_stage_ctrl #(.DELAY(16), .TW_STEP(1), .TW_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start),
    .in_ready(in_ready), .sr_en(sr_en), .bf_sel(bf_sel), .zero_in(zero_in),
    .tw_addr(tw_addr), .tw_en(tw_en), .out_valid(out_valid), .out_start(out_start),
    .busy(busy), .sync_err(sync_err)
`ifdef FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  sdf_stage_ctrl #(.DELAY(8), .TW_STEP(2), .TW_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_start(s8),
    .in_ready(ir8), .sr_en(sr8), .bf_sel(bf8), .zero_in(zi8),
    .tw_addr(ta8), .tw_en(te8), .out_valid(ov8), .out_start(os8),
    .busy(bz8), .sync_err(se8)
`ifdef FRAME_CNT_EN
    , .frame_cnt(frame_cnt8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Packed as {in_ready,sr_en,bf_sel,zero_in,out_valid,out_start,tw_en,busy,tw_addr}.
  task automatic exp_o(input string tag, input bit ir, input bit sr, input bit bf, input bit zi,
                       input bit ov, input bit os, input bit te, input bit bz, input logic [3:0] ta);
    chk(tag, {20'd0, in_ready, sr_en, bf_sel, zero_in, out_valid, out_start, tw_en, busy, tw_addr},
             {20'd0, ir, sr, bf, zi, ov, os, te, bz, ta});
  endtask

  task automatic cyc(input bit v, input bit s);
    @(negedge clk);
    in_valid = v;
    in_start = s;
    #1;
  endtask

  task automatic cyc8(input bit v, input bit s);
    @(negedge clk);
    v8 = v;
    s8 = s;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_start = 1'b0; v8 = 1'b0; s8 = 1'b0;
    @(negedge clk);
    #1;
    exp_o("reset", 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    chk("reset_sync_err", 32'(sync_err), 32'd0);
    rst = 1'b1;
  endtask

  // Samples first_i..last_i of a DELAY=16 frame; gap_a/gap_b insert 3 idle cycles after that sample.
  task automatic run_frame(input bit primed, input int first_i, input int last_i,
                           input int gap_a, input int gap_b);
    for (int i = first_i; i <= last_i; i++) begin
      cyc(1'b1, i == 0);
      exp_o("frame", 1, 1, i >= 16, 0, (i >= 16) || primed, i == 16, (i < 16) && primed,
            (i > 0) || primed, (i < 16) ? 4'(i) : 4'd0);
      if (i == gap_a || i == gap_b) begin
        for (int g = 0; g < 3; g++) begin
          cyc(1'b0, 1'b0);
          exp_o("gap", 1, 0, (i + 1) >= 16, 0, 0, 0, 0, 1, ((i + 1) < 16) ? 4'(i + 1) : 4'd0);
        end
      end
    end
  endtask

  task automatic run_flush(input int n_cycles, input bit to_idle);
    cyc(1'b0, 1'b0);
    exp_o("wrap_idle_cycle", 1, 0, 0, 0, 0, 0, 0, 1, 4'd0);
    for (int j = 0; j < n_cycles; j++) begin
      cyc(1'b1, 1'b0);
      exp_o("flush", 0, 1, 0, 1, 1, 0, 1, 1, 4'(j));
    end
    if (to_idle) begin
      cyc(1'b0, 1'b0);
      exp_o("after_flush", 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single frame then flush.
    do_reset();
    run_frame(1'b0, 0, 31, -1, -1);
    run_flush(16, 1'b1);

    // Three back-to-back frames, one flush at the end.
    do_reset();
`ifdef FRAME_CNT_EN
    chk("frame_cnt_reset", 32'(frame_cnt), 32'd0);
`endif
    run_frame(1'b0, 0, 31, -1, -1);
    run_frame(1'b1, 0, 31, -1, -1);
    run_frame(1'b1, 0, 31, -1, -1);
    run_flush(16, 1'b1);
`ifdef FRAME_CNT_EN
    chk("frame_cnt_three", 32'(frame_cnt), 32'd3);
`endif

    // Gaps inside a frame freeze the count.
    do_reset();
    run_frame(1'b0, 0, 31, 5, 20);
    run_flush(16, 1'b1);

    // Resync at cnt=7 of a primed frame.
    do_reset();
    run_frame(1'b0, 0, 31, -1, -1);
    run_frame(1'b1, 0, 6, -1, -1);
    chk("sync_err_before", 32'(sync_err), 32'd0);
    cyc(1'b1, 1'b1);
    exp_o("resync_sample", 1, 1, 0, 0, 0, 0, 0, 1, 4'd0);
    run_frame(1'b0, 1, 31, -1, -1);
    chk("sync_err_set", 32'(sync_err), 32'd1);
    run_flush(16, 1'b1);
    chk("sync_err_sticky", 32'(sync_err), 32'd1);

    // Reset during flush cycle 5.
    do_reset();
    run_frame(1'b0, 0, 31, -1, -1);
    run_flush(5, 1'b0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_o("reset_in_flush", 1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    chk("reset_in_flush_sync_err", 32'(sync_err), 32'd0);

    // DELAY=8, TW_STEP=2 instance: twiddle stride in first half of frame 2.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc8(1'b1, i == 0);
      chk("d8_frame1", {26'd0, ov8, te8, ta8}, {26'd0, i >= 8, 1'b0, (i < 8) ? 4'(2 * i) : 4'd0});
    end
    for (int i = 0; i < 8; i++) begin
      cyc8(1'b1, i == 0);
      chk("d8_frame2", {26'd0, ov8, te8, ta8}, {26'd0, 1'b1, 1'b1, 4'(2 * i)});
    end
    cyc8(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
- Sequencer for one radix-2 single-path delay feedback (R2SDF) stage of the 32-point FFT pipeline.
- Drives the stage delay line's shift enable and the butterfly/bypass select.
- Generates the twiddle ROM address and the output valid/start strobes.
- Handles the inter-frame flush that drains the delay line after the last frame.

Parameters:
- DELAY, 16, stage delay-line length (half the stage span); legal values are powers of two from 2 to 16.
- TW_STEP, 1, twiddle index stride for this stage (stage1=1, stage2=2, stage3=4, ...).
- TW_W, 4, twiddle address width.
- Local: CNT_W = $clog2(2*DELAY).

Ports:
- clk  in  1  stage clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream sample present.
- in_start  in  1  qualifies sample 0 of a frame; sampled only when in_valid=1.
- in_ready  out  1  controller accepts a sample this cycle.
- sr_en  out  1  delay-line shift enable.
- bf_sel  out  1  0 = load input into the delay line and forward the delay-line output; 1 = butterfly mode (sum forwarded, difference fed back).
- zero_in  out  1  datapath substitutes 0 for the input sample (flush).
- tw_addr  out  TW_W  twiddle ROM index.
- tw_en  out  1  multiply forwarded sample by twiddle.
- out_valid  out  1  stage output valid this cycle.
- out_start  out  1  first output sample of a frame.
- busy  out  1  state != IDLE.
- sync_err  out  1  sticky; in_start seen mid-frame.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, cnt=0, primed=0, sync_err=0. All outputs 0 except in_ready=1. Reset mid-frame or mid-flush aborts immediately; no drain.
- Accept: acc = in_valid & in_ready. All datapath controls are combinational from the registered state/cnt and acc. The controller adds zero latency.
- States:
  - IDLE: in_ready=1. acc with in_start → RUN, cnt←1. acc without in_start is dropped (sr_en=0).
  - RUN: in_ready=1. Each acc: sr_en=1, cnt←cnt+1 mod 2*DELAY. in_valid=0 freezes everything (sr_en=0, out_valid=0).
  - FLUSH: in_ready=0. For DELAY cycles: sr_en=1, zero_in=1, bf_sel=0, out_valid=1. Then primed←0 → IDLE.
- bf_sel = (cnt >= DELAY), taken from cnt before increment. In IDLE it reflects the sample being accepted with cnt treated as 0.
- out_valid = sr_en & (bf_sel | primed).
  - primed←1 when the sample with cnt=2*DELAY-1 is accepted.
  - The first half of the very first frame produces no output.
- out_start = acc & (cnt==DELAY).
- tw_addr = ((cnt mod DELAY) * TW_STEP) truncated to TW_W when bf_sel=0; 0 when bf_sel=1.
  - tw_en = out_valid & ~bf_sel.
  - During FLUSH, the flush-cycle index supplies cnt mod DELAY.
- Frame boundary: on accepting cnt=2*DELAY-1, cnt←0.
  - Next acc with in_start continues in RUN (back-to-back frames, no bubble).
  - If the next accepted sample lacks in_start, or no acc occurs for 1 cycle, → FLUSH. Any in_valid during FLUSH is not accepted.
- Resync: acc with in_start while in RUN and cnt≠0 sets sync_err=1, primed←0, cnt←1. The sample is treated as sample 0 of a new frame. The partial frame is discarded.
- sync_err clears only on reset.
- Simultaneous: in_start together with the cnt=0 wrap is the normal continue, not an error.

Optional Feature:
- FRAME_CNT_EN:
  - Defined: adds output frame_cnt [15:0]. It resets to 0, increments (wrapping at 65535) each time the last sample of a frame is accepted, and is unaffected by resync of a partial frame.
  - Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then one frame: in_start at sample 0, 32 contiguous in_valid (DELAY=16) → bf_sel=0 for samples 0–15 and 1 for 16–31. out_valid first at sample 16 with out_start=1. Then FLUSH 16 cycles with zero_in=1, out_valid=1, tw_addr 0..15. Then IDLE, busy=0.
- Two back-to-back frames → no FLUSH between them. Samples 0–15 of frame 2 have out_valid=1, tw_en=1, tw_addr=0..15. Exactly one FLUSH after frame 2.
- in_valid gaps of 3 cycles inside frame → cnt frozen, sr_en=0, out_valid=0 during gaps. Output sequence identical to the gap-free run.
- in_start at cnt=7 → sync_err=1 and stays 1; cnt restarts at 1; out_valid=0 until sample 16 of the new frame.
- DELAY=8, TW_STEP=2 → tw_addr sequence 0,2,4,...,14 during the first half of frame 2.
- rst=0 for one cycle at FLUSH cycle 5 → next cycle IDLE, all outputs 0, in_ready=1. FRAME_CNT_EN build: frame_cnt=0 after reset, equals 3 after three complete frames.
